// File: rtl/hfilter_seq.sv
// rtl/hfilter_seq.sv - edge-replicating sequencer and coefficient holder for the 3-tap hfilter
// Optional feature macro: HFILTER_SEQ_DROP_CNT_EN (adds drop_cnt_o).
module hfilter_seq #(
    parameter int DATA_WIDTH  = 8,
    parameter int COEFF_WIDTH = 14,
    parameter int COL_WIDTH   = 12,
    parameter int ROW_WIDTH   = 12
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   pix_valid_i,
    output logic                   pix_ready_o,
    input  logic [DATA_WIDTH-1:0]  pix_data_i,
    input  logic                   pix_sof_i,
    input  logic                   pix_eol_i,
    input  logic                   cfg_we_i,
    input  logic [1:0]             cfg_addr_i,
    input  logic [COEFF_WIDTH-1:0] cfg_wdata_i,
    input  logic                   cfg_commit_i,
    output logic                   filt_valid_o,
    output logic [DATA_WIDTH-1:0]  filt_data_o,
    output logic [DATA_WIDTH-1:0]  filt_center_o,
    output logic [COEFF_WIDTH-1:0] coeff00_o,
    output logic [COEFF_WIDTH-1:0] coeff01_o,
    output logic [COEFF_WIDTH-1:0] coeff02_o,
    input  logic                   filt_valid_i,
    output logic                   out_valid_o,
    output logic                   out_sof_o,
    output logic                   out_sol_o,
    output logic                   out_eol_o,
    output logic [ROW_WIDTH-1:0]   line_cnt_o,
    output logic                   commit_pend_o
`ifdef HFILTER_SEQ_DROP_CNT_EN
    ,
    output logic [15:0]            drop_cnt_o
`endif
);

    typedef enum logic [2:0] {S_IDLE, S_LSTART, S_PAD_L, S_RUN, S_POST} state_t;

    localparam int UNITY_I = 1 << (COEFF_WIDTH - 2);
    localparam logic [COEFF_WIDTH-1:0] UNITY = UNITY_I[COEFF_WIDTH-1:0];

    state_t                 state_q;
    logic                   ready_q;
    logic                   fvalid_q;
    logic [DATA_WIDTH-1:0]  fdata_q;
    logic [DATA_WIDTH-1:0]  pix_q;
    logic                   first_eol_q;
    logic                   frame_first_q;
    logic [COL_WIDTH-1:0]   k_q;
    // sideband bits: [3]=sof [2]=sol [1]=eol [0]=qual
    logic [3:0]             side_q, side_p1_q, side_p2_q;
    logic [ROW_WIDTH-1:0]   line_cnt_q;
    logic                   pend_q;
    logic [COEFF_WIDTH-1:0] sh0_q, sh1_q, sh2_q, sh0_d, sh1_d, sh2_d;
    logic [COEFF_WIDTH-1:0] act0_q, act1_q, act2_q;

    logic accept, sof_acc, sol_now, apply;

    assign accept  = pix_valid_i & ready_q;
    assign sof_acc = accept & pix_sof_i;
    assign sol_now = (k_q == COL_WIDTH'(2));
    assign apply   = pend_q & ((state_q == S_IDLE) | sof_acc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            ready_q       <= 1'b1;
            fvalid_q      <= 1'b0;
            fdata_q       <= '0;
            pix_q         <= '0;
            first_eol_q   <= 1'b0;
            frame_first_q <= 1'b0;
            k_q           <= '0;
            side_q        <= '0;
        end else begin
            fvalid_q <= 1'b0;
            side_q   <= '0;
            if (sof_acc) frame_first_q <= 1'b1;
            case (state_q)
                S_IDLE, S_LSTART: begin
                    if (accept && (pix_sof_i || state_q == S_LSTART)) begin
                        fvalid_q    <= 1'b1;
                        fdata_q     <= pix_data_i;
                        pix_q       <= pix_data_i;
                        first_eol_q <= pix_eol_i;
                        k_q         <= COL_WIDTH'(1);
                        state_q     <= S_PAD_L;
                        ready_q     <= 1'b0;
                    end
                end
                S_PAD_L: begin
                    fvalid_q <= 1'b1;
                    fdata_q  <= pix_q;
                    k_q      <= COL_WIDTH'(2);
                    state_q  <= first_eol_q ? S_POST : S_RUN;
                    ready_q  <= ~first_eol_q;
                end
                S_RUN: begin
                    if (accept && pix_sof_i) begin
                        state_q <= S_LSTART;
                    end else if (accept) begin
                        fvalid_q <= 1'b1;
                        fdata_q  <= pix_data_i;
                        pix_q    <= pix_data_i;
                        side_q   <= {sol_now & frame_first_q, sol_now, 1'b0, 1'b1};
                        k_q      <= k_q + COL_WIDTH'(1);
                        if (pix_eol_i) begin
                            state_q <= S_POST;
                            ready_q <= 1'b0;
                        end
                    end
                end
                S_POST: begin
                    fvalid_q      <= 1'b1;
                    fdata_q       <= pix_q;
                    side_q        <= {sol_now & frame_first_q, sol_now, 1'b1, 1'b1};
                    frame_first_q <= 1'b0;
                    state_q       <= S_LSTART;
                    ready_q       <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Two stages to line the sidebands up with the filter's output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            side_p1_q <= '0;
            side_p2_q <= '0;
        end else begin
            side_p1_q <= side_q;
            side_p2_q <= side_p1_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_cnt_q <= '0;
        end else if (sof_acc) begin
            line_cnt_q <= '0;
        end else if (state_q == S_POST && line_cnt_q != '1) begin
            line_cnt_q <= line_cnt_q + ROW_WIDTH'(1);
        end
    end

    always_comb begin
        sh0_d = sh0_q;
        sh1_d = sh1_q;
        sh2_d = sh2_q;
        if (cfg_we_i) begin
            case (cfg_addr_i)
                2'd0:    sh0_d = cfg_wdata_i;
                2'd1:    sh1_d = cfg_wdata_i;
                2'd2:    sh2_d = cfg_wdata_i;
                default: ;
            endcase
        end
    end

    // Copy from the next-state shadow so a write in the applying cycle is included
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh0_q  <= '0;
            sh1_q  <= UNITY;
            sh2_q  <= '0;
            act0_q <= '0;
            act1_q <= UNITY;
            act2_q <= '0;
            pend_q <= 1'b0;
        end else begin
            sh0_q <= sh0_d;
            sh1_q <= sh1_d;
            sh2_q <= sh2_d;
            if (apply) begin
                act0_q <= sh0_d;
                act1_q <= sh1_d;
                act2_q <= sh2_d;
                pend_q <= cfg_commit_i;
            end else begin
                pend_q <= pend_q | cfg_commit_i;
            end
        end
    end

`ifdef HFILTER_SEQ_DROP_CNT_EN
    logic [15:0] drop_q;
    logic        drop;
    assign drop = accept & (((state_q == S_IDLE) & ~pix_sof_i) | ((state_q == S_RUN) & pix_sof_i));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_q <= '0;
        end else if (drop && drop_q != 16'hFFFF) begin
            drop_q <= drop_q + 16'd1;
        end
    end
    assign drop_cnt_o = drop_q;
`endif

    assign pix_ready_o   = ready_q;
    assign filt_valid_o  = fvalid_q;
    assign filt_data_o   = fdata_q;
    assign filt_center_o = fdata_q;
    assign coeff00_o     = act0_q;
    assign coeff01_o     = act1_q;
    assign coeff02_o     = act2_q;
    assign out_valid_o   = filt_valid_i & side_p2_q[0];
    assign out_eol_o     = filt_valid_i & side_p2_q[1];
    assign out_sol_o     = filt_valid_i & side_p2_q[2];
    assign out_sof_o     = filt_valid_i & side_p2_q[3];
    assign line_cnt_o    = line_cnt_q;
    assign commit_pend_o = pend_q;

endmodule

// File: tb/tb_hfilter_seq.sv
// tb/tb_hfilter_seq.sv - self-checking bench for hfilter_seq with a window-level reference model
module tb_hfilter_seq;
    localparam int DW = 8;
    localparam int CW = 14;
    localparam int RW = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pix_valid_i = 1'b0, pix_sof_i = 1'b0, pix_eol_i = 1'b0;
    logic [DW-1:0] pix_data_i = '0;
    logic          pix_ready_o;
    logic          cfg_we_i = 1'b0, cfg_commit_i = 1'b0;
    logic [1:0]    cfg_addr_i = '0;
    logic [CW-1:0] cfg_wdata_i = '0;
    logic          filt_valid_o, filt_valid_i;
    logic [DW-1:0] filt_data_o, filt_center_o;
    logic [CW-1:0] coeff00_o, coeff01_o, coeff02_o;
    logic          out_valid_o, out_sof_o, out_sol_o, out_eol_o;
    logic [RW-1:0] line_cnt_o;
    logic          commit_pend_o;
`ifdef HFILTER_SEQ_DROP_CNT_EN
    logic [15:0]   drop_cnt_o;
`endif

    hfilter_seq dut (
        .clk(clk), .rst_n(rst_n),
        .pix_valid_i(pix_valid_i), .pix_ready_o(pix_ready_o), .pix_data_i(pix_data_i),
        .pix_sof_i(pix_sof_i), .pix_eol_i(pix_eol_i),
        .cfg_we_i(cfg_we_i), .cfg_addr_i(cfg_addr_i), .cfg_wdata_i(cfg_wdata_i),
        .cfg_commit_i(cfg_commit_i),
        .filt_valid_o(filt_valid_o), .filt_data_o(filt_data_o), .filt_center_o(filt_center_o),
        .coeff00_o(coeff00_o), .coeff01_o(coeff01_o), .coeff02_o(coeff02_o),
        .filt_valid_i(filt_valid_i),
        .out_valid_o(out_valid_o), .out_sof_o(out_sof_o), .out_sol_o(out_sol_o),
        .out_eol_o(out_eol_o), .line_cnt_o(line_cnt_o), .commit_pend_o(commit_pend_o)
`ifdef HFILTER_SEQ_DROP_CNT_EN
        , .drop_cnt_o(drop_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    // Stand-in for the 2-cycle-latency filter
    logic [1:0] fv;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fv <= '0;
        else        fv <= {fv[0], filt_valid_o};
    end
    assign filt_valid_i = fv[1];

    int checks = 0;
    int failures = 0;
    int exp_lines = 0;
    logic [DW-1:0] act_push[$], exp_push[$];
    logic [2:0]    act_out[$], exp_out[$];

    always @(negedge clk) begin
        if (rst_n) begin
            if (filt_valid_o) act_push.push_back(filt_data_o);
            if (out_valid_o)  act_out.push_back({out_sof_o, out_sol_o, out_eol_o});
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Each line of W pixels is the edge-padded window sequence; real outputs are centred on pixels 0..W-1
    task automatic model_line(input logic [DW-1:0] px[$], input bit first, input bit complete);
        int w = px.size();
        int n = complete ? w : w - 1;
        exp_push.push_back(px[0]);
        for (int i = 0; i < w; i++) exp_push.push_back(px[i]);
        if (complete) exp_push.push_back(px[w-1]);
        for (int c = 0; c < n; c++)
            exp_out.push_back({first && c == 0, c == 0, complete && c == w - 1});
        if (complete) exp_lines++;
    endtask

    task automatic beat(input logic [DW-1:0] d, input logic sof, input logic eol);
        bit taken = 0;
        pix_valid_i = 1'b1; pix_data_i = d; pix_sof_i = sof; pix_eol_i = eol;
        for (int n = 0; n < 16 && !taken; n++) begin
            taken = pix_ready_o;
            @(negedge clk);
        end
        if (!taken) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        pix_valid_i = 1'b0; pix_sof_i = 1'b0; pix_eol_i = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_line(input logic [DW-1:0] px[$], input bit sof, input bit gaps);
        if (sof) exp_lines = 0;
        model_line(px, sof, 1'b1);
        for (int i = 0; i < px.size(); i++) begin
            if (gaps && $urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
            beat(px[i], sof && i == 0, i == px.size() - 1);
        end
        idle(0);
    endtask

    task automatic drain_compare(input string name);
        idle(6);
        chk({name, "_push_count"}, act_push.size(), exp_push.size());
        for (int i = 0; i < exp_push.size() && i < act_push.size(); i++)
            chk({name, "_push_data"}, 32'(act_push[i]), 32'(exp_push[i]));
        chk({name, "_out_count"}, act_out.size(), exp_out.size());
        for (int i = 0; i < exp_out.size() && i < act_out.size(); i++)
            chk({name, "_out_sof_sol_eol"}, 32'(act_out[i]), 32'(exp_out[i]));
        chk({name, "_line_cnt"}, 32'(line_cnt_o), exp_lines);
        act_push.delete(); exp_push.delete(); act_out.delete(); exp_out.delete();
    endtask

    typedef struct {
        logic          we;
        logic [1:0]    addr;
        logic [CW-1:0] wdata;
        logic          commit;
        logic [CW-1:0] e0, e1, e2;
        logic          epend;
    } cfg_vec_t;

    cfg_vec_t tbl[8];
    logic [DW-1:0] px[$];

    initial begin
        tbl[0] = '{1'b1, 2'd0, 14'h0005, 1'b0, 14'h0000, 14'h1000, 14'h0000, 1'b0};
        tbl[1] = '{1'b1, 2'd3, 14'h3FFF, 1'b0, 14'h0000, 14'h1000, 14'h0000, 1'b0};
        tbl[2] = '{1'b1, 2'd2, 14'h002A, 1'b1, 14'h0000, 14'h1000, 14'h0000, 1'b1};
        tbl[3] = '{1'b0, 2'd0, 14'h0000, 1'b0, 14'h0005, 14'h1000, 14'h002A, 1'b0};
        tbl[4] = '{1'b1, 2'd1, 14'h0123, 1'b1, 14'h0005, 14'h1000, 14'h002A, 1'b1};
        tbl[5] = '{1'b0, 2'd0, 14'h0000, 1'b0, 14'h0005, 14'h0123, 14'h002A, 1'b0};
        tbl[6] = '{1'b0, 2'd0, 14'h0000, 1'b1, 14'h0005, 14'h0123, 14'h002A, 1'b1};
        tbl[7] = '{1'b0, 2'd0, 14'h0000, 1'b0, 14'h0005, 14'h0123, 14'h002A, 1'b0};

        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(pix_ready_o), 1);
        chk("rst_filt_valid", 32'(filt_valid_o), 0);
        chk("rst_filt_data", 32'(filt_data_o), 0);
        chk("rst_out", 32'({out_valid_o, out_sof_o, out_sol_o, out_eol_o}), 0);
        chk("rst_line_cnt", 32'(line_cnt_o), 0);
        chk("rst_pend", 32'(commit_pend_o), 0);
        chk("rst_coeffs", {coeff00_o, coeff01_o, coeff02_o[3:0]}, {14'h0000, 14'h1000, 4'h0});
        chk("rst_coeff02", 32'(coeff02_o), 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            cfg_we_i = tbl[i].we; cfg_addr_i = tbl[i].addr;
            cfg_wdata_i = tbl[i].wdata; cfg_commit_i = tbl[i].commit;
            @(negedge clk);
            chk("cfg_coeff00", 32'(coeff00_o), 32'(tbl[i].e0));
            chk("cfg_coeff01", 32'(coeff01_o), 32'(tbl[i].e1));
            chk("cfg_coeff02", 32'(coeff02_o), 32'(tbl[i].e2));
            chk("cfg_pend", 32'(commit_pend_o), 32'(tbl[i].epend));
        end
        cfg_we_i = 1'b0; cfg_commit_i = 1'b0;

        beat(8'd1, 1'b0, 1'b0); beat(8'd2, 1'b0, 1'b1); beat(8'd3, 1'b0, 1'b0);
        drain_compare("idle_discard");
`ifdef HFILTER_SEQ_DROP_CNT_EN
        chk("drop_cnt_idle", 32'(drop_cnt_o), 3);
`endif

        px = '{8'd10, 8'd20, 8'd30, 8'd40};
        send_line(px, 1'b1, 1'b0);
        drain_compare("line4");

        px = '{8'd77};
        send_line(px, 1'b1, 1'b0);
        drain_compare("line1");

        px = '{8'd1, 8'd2, 8'd3};
        send_line(px, 1'b1, 1'b0);
        cfg_we_i = 1'b1; cfg_addr_i = 2'd1; cfg_wdata_i = 14'h0800; cfg_commit_i = 1'b1;
        @(negedge clk);
        cfg_we_i = 1'b0; cfg_commit_i = 1'b0;
        chk("midframe_pend_set", 32'(commit_pend_o), 1);
        px = '{8'd4, 8'd5};
        send_line(px, 1'b0, 1'b1);
        chk("midframe_coeff01_held", 32'(coeff01_o), 32'h0123);
        chk("midframe_pend_held", 32'(commit_pend_o), 1);
        exp_lines = 0;
        px = '{8'd8, 8'd9};
        model_line(px, 1'b1, 1'b1);
        beat(8'd8, 1'b1, 1'b0);
        chk("sof_coeff01_applied", 32'(coeff01_o), 32'h0800);
        chk("sof_pend_cleared", 32'(commit_pend_o), 0);
        beat(8'd9, 1'b0, 1'b1);
        drain_compare("commit_frame");

        exp_lines = 0;
        px = '{8'd5, 8'd6};
        model_line(px, 1'b1, 1'b0);
        px = '{8'd11, 8'd12};
        model_line(px, 1'b1, 1'b1);
        beat(8'd5, 1'b1, 1'b0); beat(8'd6, 1'b0, 1'b0); beat(8'd9, 1'b1, 1'b0);
        beat(8'd11, 1'b0, 1'b0); beat(8'd12, 1'b0, 1'b1);
        drain_compare("sof_in_run");
`ifdef HFILTER_SEQ_DROP_CNT_EN
        chk("drop_cnt_run", 32'(drop_cnt_o), 4);
`endif

        for (int f = 0; f < 4; f++) begin
            int nl = $urandom_range(1, 3);
            for (int l = 0; l < nl; l++) begin
                int w = $urandom_range(1, 6);
                px.delete();
                for (int i = 0; i < w; i++) px.push_back(DW'($urandom_range(0, 255)));
                send_line(px, l == 0, 1'b1);
            end
            drain_compare("random_frame");
        end

        px = '{8'd3, 8'd4};
        send_line(px, 1'b1, 1'b0);
        drain_compare("pre_reset");
        beat(8'd7, 1'b0, 1'b0); beat(8'd8, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_ready", 32'(pix_ready_o), 1);
        chk("async_rst_filt_valid", 32'(filt_valid_o), 0);
        chk("async_rst_line_cnt", 32'(line_cnt_o), 0);
        idle(1);
        rst_n = 1'b1;
        act_push.delete(); act_out.delete(); exp_lines = 0;
        px = '{8'd50, 8'd60, 8'd70};
        send_line(px, 1'b1, 1'b1);
        drain_compare("post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
